// File: rtl/fetch_if.sv
// Fetch-queue bundle: memory read port, redirect request and decode-side instruction handshake.
interface fetch_if #(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16
) ();
  logic                 mem_rd;
  logic [BITS_ADDR-1:0] mem_addr;
  logic [BITS_DATA-1:0] mem_rdata;
  logic                 redirect;
  logic [BITS_ADDR-1:0] redirect_pc;
  logic [BITS_DATA-1:0] ir;
  logic [BITS_ADDR-1:0] ir_pc;
  logic                 ir_valid;
  logic                 ir_ready;

  modport master (
    output mem_rd, mem_addr, ir, ir_pc, ir_valid,
    input  mem_rdata, redirect, redirect_pc, ir_ready
  );

  modport slave (
    input  mem_rd, mem_addr, ir, ir_pc, ir_valid,
    output mem_rdata, redirect, redirect_pc, ir_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one-word-per-cycle memory fetch into a DEPTH-entry FIFO with redirect.
// Define FETCH_STALL_CNT_EN to add the saturating 16-bit stall_cnt_o output.
module fetch_queue #(
  parameter int unsigned          BITS_DATA = 32,
  parameter int unsigned          BITS_ADDR = 16,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [BITS_ADDR-1:0] RESET_PC  = '0
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] OccLimit = (CntW + 1)'(DEPTH);

  logic [BITS_DATA-1:0] word_q [DEPTH];
  logic [BITS_ADDR-1:0] addr_q [DEPTH];

  logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [BITS_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic [BITS_ADDR-1:0] inflight_pc_q, inflight_pc_d;
  logic                 inflight_q, inflight_d;

  logic [CntW:0]        occupancy;
  logic                 issue, write_en, pop, valid;

  // An outstanding read reserves its slot, so the queue can never overflow.
  assign occupancy = {1'b0, count_q} + (CntW + 1)'(inflight_q);
  assign issue     = !reset && !bus.redirect && (occupancy < OccLimit);
  assign write_en  = inflight_q && !bus.redirect;
  assign valid     = !reset && !bus.redirect && (count_q != '0);
  assign pop       = valid && bus.ir_ready;

  assign bus.mem_rd   = issue;
  assign bus.mem_addr = fetch_pc_q;
  assign bus.ir_valid = valid;
  assign bus.ir       = word_q[head_q];
  assign bus.ir_pc    = addr_q[head_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + BITS_ADDR'(1);
      end
      if (write_en) tail_d = tail_q + PtrW'(1);
      if (pop)      head_d = head_q + PtrW'(1);
      case ({write_en, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && write_en) begin
      word_q[tail_q] <= bus.mem_rdata;
      addr_q[tail_q] <= inflight_pc_q;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: queue-based reference model feeds a scoreboard checked by a
// separate transfer monitor; per-cycle mem_rd/mem_addr/ir_valid timing is compared as well.
module tb_fetch_queue;
  localparam int unsigned   BD = 32;
  localparam int unsigned   BA = 16;
  localparam int unsigned   DEPTH = 4;
  localparam logic [15:0]   RST_PC = 16'h0000;

  typedef struct {
    logic [31:0] w;
    logic [15:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fetch_if #(.BITS_DATA(BD), .BITS_ADDR(BA)) bus ();

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fetch_queue #(
    .BITS_DATA(BD), .BITS_ADDR(BA), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory: word = 0xA000_0000 + address one cycle after the strobe; junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= 32'hA000_0000 + 32'(bus.mem_addr);
    else            bus.mem_rdata <= $urandom;
  end

  int   n_total = 0;
  int   n_pass  = 0;
  ent_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: fetch pointer, one outstanding read, and a plain queue of fetched entries.
  initial begin
    ent_t        mq[$];
    logic [15:0] m_pc = RST_PC;
    logic [15:0] m_fl_pc = RST_PC;
    bit          m_fl = 1'b0;
    int          m_stall = 0;
    bit          e_rd, e_valid;
    forever begin
      @(negedge clk);
      e_rd    = !reset && !bus.redirect && (mq.size() + int'(m_fl) < int'(DEPTH));
      e_valid = !reset && !bus.redirect && (mq.size() != 0);
      check("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
      check("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
      check("ir_valid", 32'(bus.ir_valid), 32'(e_valid));
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
      if (e_valid && bus.ir_ready) exp_q.push_back(mq[0]);
      if (reset) begin
        mq.delete(); m_fl = 1'b0; m_pc = RST_PC; m_stall = 0;
      end else begin
        if (!e_valid && m_stall < 65535) m_stall++;
        if (bus.redirect) begin
          mq.delete(); m_fl = 1'b0; m_pc = bus.redirect_pc;
        end else begin
          if (e_valid && bus.ir_ready) void'(mq.pop_front());
          if (m_fl) mq.push_back('{w: 32'hA000_0000 + 32'(m_fl_pc), pc: m_fl_pc});
          m_fl = e_rd;
          if (e_rd) begin
            m_fl_pc = m_pc;
            m_pc    = m_pc + 16'd1;
          end
        end
      end
    end
  end

  // Monitor: every accepted instruction must be the next one the model expects.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.ir_valid === 1'b1 && bus.ir_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got ir_pc %h expected no transfer at %0t", bus.ir_pc,
                   $time);
        end else begin
          e = exp_q.pop_front();
          check("ir_pc", 32'(bus.ir_pc), 32'(e.pc));
          check("ir", bus.ir, e.w);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic rd, input logic [15:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset = rst; bus.redirect = rd; bus.redirect_pc = rpc; bus.ir_ready = rdy;
  endtask

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.ir_ready = 1'b1;
    repeat (3)  step(1'b1, 1'b0, 16'h0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 16'h0, 1'b1);       // streaming from reset
    repeat (10) step(1'b0, 1'b0, 16'h0, 1'b0);       // fill and stall
    repeat (6)  step(1'b0, 1'b0, 16'h0, 1'b1);       // drain in order
    step(1'b0, 1'b1, 16'h0100, 1'b0);
    repeat (4)  step(1'b0, 1'b0, 16'h0, 1'b0);       // 3 queued + 1 in flight
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    repeat (6)  step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'hFFFE, 1'b1);                // address wrap
    repeat (8)  step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0200, 1'b1);                // back-to-back redirects
    step(1'b0, 1'b1, 16'h0300, 1'b1);
    repeat (6)  step(1'b0, 1'b0, 16'h0, 1'b1);
    repeat (4)  step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0500, 1'b0);                // reset beats redirect
    step(1'b1, 1'b0, 16'h0, 1'b0);
    repeat (6)  step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 4),
           16'($urandom), ($urandom_range(0, 99) < 70));
    end
    repeat (3)  step(1'b0, 1'b0, 16'h0, 1'b1);
    @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter BITS_DATA, default 32, instruction/data word width.
REQ-002 Parameter BITS_ADDR, default 16, word address width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 mem_rd  output  1  memory read strobe; one word requested per high cycle.
REQ-008 mem_addr  output  BITS_ADDR  read address; equals fetch_pc at all times.
REQ-009 mem_rdata  input  BITS_DATA  read data, valid the cycle after the matching mem_rd.
REQ-010 redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
REQ-011 redirect_pc  input  BITS_ADDR  new fetch address, sampled when redirect=1.
REQ-012 ir  output  BITS_DATA  instruction word at queue head, to decode.
REQ-013 ir_pc  output  BITS_ADDR  address of ir.
REQ-014 ir_valid  output  1  head entry present.
REQ-015 ir_ready  input  1  decode accepts head; transfer when ir_valid and ir_ready are both 1.

Function
REQ-016 Internal state: fetch_pc, 1-bit inflight flag, circular queue of DEPTH entries {word, pc}, head/tail pointers, count 0..DEPTH.
REQ-017 mem_rd is 1 iff reset=0, redirect=0, and count+inflight < DEPTH; the pop of the same cycle is not credited.
REQ-018 On issue: fetch_pc increments by 1 modulo 2^BITS_ADDR (0xFFFF wraps to 0x0000); inflight set to 1, else cleared.
REQ-019 When inflight=1 and redirect=0, mem_rdata and its address are written at tail; tail advances modulo DEPTH.
REQ-020 ir_valid = (count != 0) and redirect=0; ir/ir_pc show head entry combinationally; their values are don't-care when ir_valid=0.
REQ-021 A transfer advances head modulo DEPTH; simultaneous write and transfer leave count unchanged.
REQ-022 Sustained throughput: one instruction per cycle when ir_ready is held 1.
REQ-023 Full (count=DEPTH): no issue; stall holds until a transfer frees an entry; no entry ever overwritten.
REQ-024 Redirect has priority over every other event: count, head and tail cleared; inflight cleared; any returning mem_rdata discarded; fetch_pc loaded with redirect_pc; no mem_rd that cycle.
REQ-025 Redirect latency: redirect in cycle N; mem_rd with mem_addr=redirect_pc in N+1; entry written in N+2; ir_valid=1 in N+3.
REQ-026 Back-to-back redirects: last one wins; each restarts the REQ-025 timing.
REQ-027 mem_rdata is never sampled in a cycle whose previous cycle had no mem_rd.

Reset
REQ-028 While reset=1: mem_rd=0, ir_valid=0, count=0, head=tail=0, inflight=0, fetch_pc=RESET_PC, so mem_addr=RESET_PC.
REQ-029 First mem_rd in the first cycle with reset=0; first ir_valid=1 two cycles later.
REQ-030 Reset mid-operation discards all queued and in-flight words; a redirect coincident with reset is ignored.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN: when defined, adds output stall_cnt, 16 bits, the count of cycles with reset=0 and ir_valid=0; saturates at 0xFFFF; cleared by reset.
REQ-032 Without FETCH_STALL_CNT_EN the port and counter are absent; all other behaviour is identical.

Verification
REQ-033 Reset release, ir_ready=1, memory returns word = 0xA000_0000+address -> mem_addr 0,1,2,...; ir=0xA0000000 with ir_pc=0 two cycles after release, then one instruction per cycle.
REQ-034 ir_ready=0 after release -> exactly 4 mem_rd pulses (addresses 0..3), count=4, mem_rd stays 0; raise ir_ready -> ir_pc 0,1,2,3 in order, no loss or duplication.
REQ-035 Redirect to 0x0040 while queue holds 3 entries and a read is in flight -> flushed; mem_addr=0x0040 next cycle; ir_pc=0x0040 three cycles after redirect; no stale word delivered.
REQ-036 RESET_PC=0xFFFE, ir_ready=1 -> ir_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-037 Reset asserted with 2 queued entries -> ir_valid=0 and mem_rd=0 next cycle; after release fetch restarts at RESET_PC.
REQ-038 With FETCH_STALL_CNT_EN, ir_ready=1, redirect pulsed once -> stall_cnt=2 after startup, incremented by 3 after the redirect.
